// File: rtl/bar_level_render_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | bar_level_render_if : level write bus (request / ack)             |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface bar_level_render_if #(
  parameter int LEVEL_W = 7
);
  logic               lvl_wr;
  logic [3:0]         lvl_addr;
  logic [LEVEL_W-1:0] lvl_data;
  logic               lvl_ack;

  modport master (output lvl_wr, output lvl_addr, output lvl_data, input lvl_ack);
  modport slave  (input lvl_wr, input lvl_addr, input lvl_data, output lvl_ack);
endinterface
`default_nettype wire

// File: rtl/bar_level_render.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | bar_level_render : per-pixel bar / peak-marker renderer           |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module bar_level_render #(
  parameter int BAR_COUNT         = 11,
  parameter int LEVEL_W           = 7,
  parameter int Y_BASE            = 400,
  parameter int PEAK_HOLD_FRAMES  = 30,
  parameter int PEAK_DECAY_FRAMES = 2
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic [11:0]          CounterX,
  input  wire logic [11:0]          CounterY,
  input  wire logic [BAR_COUNT-1:0] bar_sel,
  input  wire logic                 frame_start,
  bar_level_render_if.slave         wr,
  output logic                      bar_on,
  output logic                      peak_on,
  output logic [3:0]                bar_idx,
  output logic [11:0]               CounterX_d
);
  localparam int c_HOLD_MAX = (PEAK_HOLD_FRAMES > PEAK_DECAY_FRAMES) ? PEAK_HOLD_FRAMES : PEAK_DECAY_FRAMES;
  localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);

  logic [LEVEL_W-1:0]  r_pending [BAR_COUNT];
  logic [LEVEL_W-1:0]  r_active  [BAR_COUNT];
  logic [LEVEL_W-1:0]  r_peak    [BAR_COUNT];
  logic [c_HOLD_W-1:0] r_hold    [BAR_COUNT];
  logic                r_ack;

  logic               w_accept;
  logic               w_sel;
  logic [3:0]         w_idx;
  logic [LEVEL_W-1:0] w_act;
  logic [LEVEL_W-1:0] w_pk;
  logic [12:0]        w_dy;
  logic               w_bar;
  logic               w_peak;

  // Writes stall during frame_start so the swap always sees a stable pending bank.
  assign w_accept = wr.lvl_wr & ~frame_start & (int'(wr.lvl_addr) < BAR_COUNT);
  assign wr.lvl_ack = r_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      for (int i = 0; i < BAR_COUNT; i++) begin
        r_pending[i] <= '0;
        r_active[i]  <= '0;
        r_peak[i]    <= '0;
        r_hold[i]    <= '0;
      end
    end else begin
      r_ack <= w_accept;
      if (w_accept)
        r_pending[wr.lvl_addr] <= wr.lvl_data;
      if (frame_start) begin
        for (int i = 0; i < BAR_COUNT; i++) begin
          r_active[i] <= r_pending[i];
          // peak > 0 is guaranteed in the decay branch: level 0 >= peak 0 always recaptures
          if (r_pending[i] >= r_peak[i]) begin
            r_peak[i] <= r_pending[i];
            r_hold[i] <= c_HOLD_W'(PEAK_HOLD_FRAMES);
          end else if (r_hold[i] != '0) begin
            r_hold[i] <= r_hold[i] - c_HOLD_W'(1);
          end else begin
            r_peak[i] <= r_peak[i] - LEVEL_W'(1);
            r_hold[i] <= c_HOLD_W'(PEAK_DECAY_FRAMES - 1);
          end
        end
      end
    end
  end

  // Lowest set flag wins where adjacent decoder ranges share a pixel.
  always_comb begin
    w_idx = '0;
    for (int i = BAR_COUNT - 1; i >= 0; i--)
      if (bar_sel[i])
        w_idx = 4'(i);
  end

  assign w_sel  = |bar_sel;
  assign w_act  = r_active[w_idx];
  assign w_pk   = r_peak[w_idx];
  assign w_dy   = 13'(Y_BASE) - {1'b0, CounterY};
  assign w_bar  = w_sel & ~w_dy[12] & (w_dy[11:0] < 12'(w_act));
  assign w_peak = w_sel & (w_pk != '0) & ~w_dy[12] & (w_dy[11:0] == 12'(w_pk));

  always_ff @(posedge clk) begin
    if (reset) begin
      bar_on     <= 1'b0;
      peak_on    <= 1'b0;
      bar_idx    <= '0;
      CounterX_d <= '0;
    end else begin
      bar_on     <= w_bar;
      peak_on    <= w_peak;
      bar_idx    <= w_idx;
      CounterX_d <= CounterX;
    end
  end
endmodule
`default_nettype wire

// File: doc/bar_level_render.md
# bar_level_render

Per-pixel renderer for the synth parameter bar display. It sits directly downstream of the 11-column bar-select decoder. It consumes that decoder's column-enable flags together with the raster counters, and produces bar and peak-marker pixel enables for the colour mux. Bar levels are written by the control side into a pending bank, which is swapped into the display bank once per frame. Each bar has a peak-hold marker with timed decay.

## Interface
- BAR_COUNT, 11, number of bars; bar i is selected by bar_sel[i].
- LEVEL_W, 7, bar level width (levels 0..2^LEVEL_W-1 pixels tall).
- Y_BASE, 400, raster row of the bar baseline (bottom pixel row of every bar).
- PEAK_HOLD_FRAMES, 30, frames a new peak is held before decay starts.
- PEAK_DECAY_FRAMES, 2, frames per 1-pixel peak decay step (minimum 1).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- CounterX  in  12  raster column (passed through for alignment only).
- CounterY  in  12  raster row.
- bar_sel  in  BAR_COUNT  column flags from the decoder: bit0=Lu4, 1=Lu5, 2=Lu6, 3=Mu1, 4=Mu2, 5=Mu4, 6=Mu5, 7=Mu6, 8=Hu1, 9=Hu2, 10=Hu4.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- lvl_wr  in  1  level write request.
- lvl_addr  in  4  bar index for write.
- lvl_data  in  LEVEL_W  level value.
- lvl_ack  out  1  one-cycle pulse, write accepted.
- bar_on  out  1  pixel lies inside a bar body.
- peak_on  out  1  pixel lies on a peak marker row.
- bar_idx  out  4  index of selected bar (0 when none).
- CounterX_d  out  12  CounterX delayed to match outputs.

## Operation
- Reset: pending[], active[], peak[] and hold[] are cleared to 0. bar_on, peak_on, lvl_ack, bar_idx and CounterX_d are all 0.
- Write port:
  - A write is accepted when lvl_wr=1, frame_start=0 and lvl_addr<BAR_COUNT. Acceptance sets pending[lvl_addr] <= lvl_data and pulses lvl_ack on the next cycle.
  - When frame_start=1, the write is not accepted. The master holds lvl_wr until it sees lvl_ack.
  - A write with lvl_addr>=BAR_COUNT is dropped and no ack is issued.
  - Back-to-back writes are allowed: one per cycle, one ack each.
- Frame swap, on frame_start, for every bar i using the pre-swap pending value n=pending[i]:
  - active[i] <= n.
  - If n>=peak[i]: peak[i] <= n and hold[i] <= PEAK_HOLD_FRAMES.
  - Else if hold[i]!=0: hold[i] <= hold[i]-1.
  - Else: peak[i] <= peak[i]-1 and hold[i] <= PEAK_DECAY_FRAMES-1.
- Because of the swap rules, the peak never drops below the active level.
- Bar selection:
  - idx is the lowest set bit of bar_sel. Adjacent decoder ranges overlap on their shared boundary pixel, and the lower bar wins there.
  - No bit set means no bar is selected.
- Pixel decision, with dy = Y_BASE - CounterY computed 13-bit signed:
  - bar_on = selected && dy>=0 && dy<active[idx].
  - peak_on = selected && peak[idx]!=0 && dy==peak[idx].
  - bar_on and peak_on are never both 1.
- Level 0 draws nothing.

## Timing
- Pixel path latency is one cycle: inputs at cycle t give bar_on, peak_on, bar_idx and CounterX_d at t+1. All outputs are registered.
- A frame_start at cycle t makes the new active and peak values visible to pixel inputs from cycle t+1 on.
- A write accepted at t raises lvl_ack at t+1. The written value is displayed only after the next frame_start.
- A write and frame_start in the same cycle: the swap uses the old pending value, and the write is stalled.
- Reset asserted mid-frame clears all state in one cycle. Outputs are 0 in the cycle after reset is sampled.

## Test plan
- Write addr0=10 then pulse frame_start. Inputs CounterY=395, bar_sel=0x001 -> bar_on=1, bar_idx=0 one cycle later. CounterY=390 -> bar_on=0, peak_on=1.
- Set bar_sel=0x003 (boundary pixel) with active[0]=0 and active[1]=50, CounterY=380 -> bar_idx=0, bar_on=0.
- Assert lvl_wr in the same cycle as frame_start -> no lvl_ack that cycle. Hold lvl_wr -> lvl_ack on the cycle after frame_start drops. The written value is absent from the display until the next frame_start.
- Peak decay: frame 1 with level 20, all later frames level 0. Required: peak=20 through frame 31, 19 at frame 32, 19 at frame 33, 18 at frame 34.
- lvl_addr=11 with lvl_wr=1 -> no ack and no state change. Reset pulse mid-frame -> all outputs 0 next cycle, and a bar with level 10 is no longer drawn.
